// File: rtl/psk_tx_controller.sv
`default_nettype none
// ============================================================================
//  Module      : psk_tx_controller
//  Description : Burst controller for a BPSK/QPSK transmitter. A debounced
//                push-button press arms the sine generator, waits until the
//                generator and the data source are ready, then paces one
//                burst of BURST_SYMS symbols of SPS samples each.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   sole clock, rising edge
//    rst           in   asynchronous active-high reset
//    PB            in   raw push-button, asynchronous to clk
//    mode          in   0 = BPSK, 1 = QPSK, latched at the accepted press
//    sine_rdy      in   sine generator output valid
//    data_rdy      in   source bit(s) available
//    sine_rst      out  sine generator reset
//    sine_clk_en   out  sine generator clock enable
//    mod_en        out  modulator enable
//    sym_strobe    out  one-cycle pulse at the last sample of each symbol
//    bits_per_sym  out  1 (BPSK) or 2 (QPSK)
//    busy          out  high outside IDLE and ERROR
//    done          out  one-cycle pulse at the end of a burst
//    err           out  sticky timeout / generator-fault flag
// ============================================================================
module psk_tx_controller #(
    parameter int SPS        = 8,
    parameter int BURST_SYMS = 64,
    parameter int DEBOUNCE   = 16,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PB,
    input  logic       mode,
    input  logic       sine_rdy,
    input  logic       data_rdy,
    output logic       sine_rst,
    output logic       sine_clk_en,
    output logic       mod_en,
    output logic       sym_strobe,
    output logic [1:0] bits_per_sym,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Counter widths: $clog2 of the parameter, never narrower than 1 bit
    localparam int c_SPS_W = (SPS        > 1) ? $clog2(SPS)        : 1;
    localparam int c_SYM_W = (BURST_SYMS > 1) ? $clog2(BURST_SYMS) : 1;
    localparam int c_DB_W  = (DEBOUNCE   > 1) ? $clog2(DEBOUNCE)   : 1;
    localparam int c_ARM_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int c_TO_W  = (TIMEOUT    > 1) ? $clog2(TIMEOUT)    : 1;

    // Terminal counts
    localparam logic [c_SPS_W-1:0] c_SPS_LAST = c_SPS_W'(SPS - 1);
    localparam logic [c_SYM_W-1:0] c_SYM_LAST = c_SYM_W'(BURST_SYMS - 1);
    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE - 1);
    localparam logic [c_ARM_W-1:0] c_ARM_LAST = c_ARM_W'(RST_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERROR    = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               pb_meta_q,  pb_meta_d;
    logic               pb_sync_q,  pb_sync_d;
    logic               db_level_q, db_level_d;
    logic [c_DB_W-1:0]  db_cnt_q,   db_cnt_d;
    logic               press_q,    press_d;
    state_t             state_q,    state_d;
    logic               mode_q,     mode_d;
    logic               err_q,      err_d;
    logic [c_ARM_W-1:0] arm_cnt_q,  arm_cnt_d;
    logic [c_TO_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [c_SPS_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [c_SYM_W-1:0] sym_cnt_q,  sym_cnt_d;

    // ------------------------------------------------------------------
    // Synchroniser and debouncer
    // ------------------------------------------------------------------
    // The debounced level only follows the synchronised input once it has
    // differed for DEBOUNCE consecutive cycles; any bounce restarts the
    // count. The press event is registered together with the rising level
    // so it lasts exactly one cycle.
    always_comb begin
        pb_meta_d  = PB;
        pb_sync_d  = pb_meta_q;
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        press_d    = 1'b0;
        if (pb_sync_q != db_level_q) begin
            if (db_cnt_q == c_DB_LAST) begin
                db_level_d = pb_sync_q;
                press_d    = pb_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        err_d        = err_q;
        // Counters clear whenever they are not explicitly advanced or held,
        // so every state exit leaves them at zero.
        arm_cnt_d    = '0;
        wait_cnt_d   = '0;
        samp_cnt_d   = '0;
        sym_cnt_d    = '0;

        sine_rst     = 1'b1;
        sine_clk_en  = 1'b0;
        mod_en       = 1'b0;
        sym_strobe   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (press_q) begin
                    mode_d  = mode;
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                if (press_q) begin
                    state_d = ST_IDLE;
                end else if (arm_cnt_q == c_ARM_LAST) begin
                    state_d = ST_WAIT_RDY;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end

            ST_WAIT_RDY: begin
                sine_rst    = 1'b0;
                sine_clk_en = 1'b1;
                if (press_q) begin
                    state_d = ST_IDLE;
                end else if (sine_rdy && data_rdy) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == c_TO_LAST) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                sine_rst    = 1'b0;
                sine_clk_en = 1'b1;
                mod_en      = data_rdy;
                sym_strobe  = data_rdy && (samp_cnt_q == c_SPS_LAST);
                if (press_q) begin
                    state_d = ST_IDLE;
                end else if (!sine_rdy) begin
                    // Generator lost validity mid-burst: a fault, not a pause
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    samp_cnt_d = samp_cnt_q;
                    sym_cnt_d  = sym_cnt_q;
                    if (data_rdy) begin
                        if (samp_cnt_q == c_SPS_LAST) begin
                            samp_cnt_d = '0;
                            if (sym_cnt_q == c_SYM_LAST) begin
                                sym_cnt_d = '0;
                                state_d   = ST_DONE;
                            end else begin
                                sym_cnt_d = sym_cnt_q + 1'b1;
                            end
                        end else begin
                            samp_cnt_d = samp_cnt_q + 1'b1;
                        end
                    end
                end
            end

            ST_DONE: begin
                sine_rst = 1'b0;
                done     = 1'b1;
                state_d  = ST_IDLE;
            end

            ST_ERROR: begin
                busy = 1'b0;
                if (press_q) begin
                    err_d   = 1'b0;
                    mode_d  = mode;
                    state_d = ST_ARM;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign err          = err_q;
    assign bits_per_sym = mode_q ? 2'd2 : 2'd1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pb_meta_q  <= 1'b0;
            pb_sync_q  <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            err_q      <= 1'b0;
            arm_cnt_q  <= '0;
            wait_cnt_q <= '0;
            samp_cnt_q <= '0;
            sym_cnt_q  <= '0;
        end else begin
            pb_meta_q  <= pb_meta_d;
            pb_sync_q  <= pb_sync_d;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
            arm_cnt_q  <= arm_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psk_tx_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psk_tx_controller
//  Description : Directed self-checking bench for psk_tx_controller with
//                SPS=4, BURST_SYMS=3, DEBOUNCE=4, RST_CYCLES=2, TIMEOUT=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psk_tx_controller;

    localparam int c_S_IDLE = 0;
    localparam int c_S_ARM  = 1;
    localparam int c_S_WAIT = 2;
    localparam int c_S_RUN  = 3;
    localparam int c_S_DONE = 4;
    localparam int c_S_ERR  = 5;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       pb       = 1'b0;
    logic       mode     = 1'b0;
    logic       sine_rdy = 1'b0;
    logic       data_rdy = 1'b0;
    logic       sine_rst, sine_clk_en, mod_en, sym_strobe, busy, done, err;
    logic [1:0] bits_per_sym;
    logic [8:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       pb;
        logic       mode;
        logic       srdy;
        logic       drdy;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs [25];

    psk_tx_controller #(
        .SPS        (4),
        .BURST_SYMS (3),
        .DEBOUNCE   (4),
        .RST_CYCLES (2),
        .TIMEOUT    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PB           (pb),
        .mode         (mode),
        .sine_rdy     (sine_rdy),
        .data_rdy     (data_rdy),
        .sine_rst     (sine_rst),
        .sine_clk_en  (sine_clk_en),
        .mod_en       (mod_en),
        .sym_strobe   (sym_strobe),
        .bits_per_sym (bits_per_sym),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // {sine_rst, sine_clk_en, mod_en, sym_strobe, busy, done, err, bits[1:0]}
    assign obs = {sine_rst, sine_clk_en, mod_en, sym_strobe, busy, done, err, bits_per_sym};

    function automatic logic [8:0] ev(int st, logic dr, logic stb, logic [1:0] bits);
        case (st)
            c_S_IDLE: ev = {7'b1000000, bits};
            c_S_ARM:  ev = {7'b1000100, bits};
            c_S_WAIT: ev = {7'b0100100, bits};
            c_S_RUN:  ev = {2'b01, dr, stb, 3'b100, bits};
            c_S_DONE: ev = {7'b0000110, bits};
            default:  ev = {7'b1000001, bits};
        endcase
    endfunction

    task automatic cyc(input logic p, input logic m, input logic s, input logic d);
        @(negedge clk);
        pb       = p;
        mode     = m;
        sine_rdy = s;
        data_rdy = d;
        #2;
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    initial begin : main
        int st;
        int nstb;

        // Nominal BPSK burst, one record per cycle (cycle 0 = first PB-high cycle)
        for (int c = 0; c < 25; c++) begin
            if (c <= 6)       st = c_S_IDLE;
            else if (c <= 8)  st = c_S_ARM;
            else if (c == 9)  st = c_S_WAIT;
            else if (c <= 21) st = c_S_RUN;
            else if (c == 22) st = c_S_DONE;
            else              st = c_S_IDLE;
            vecs[c].pb   = (c < 8);
            vecs[c].mode = 1'b0;
            vecs[c].srdy = 1'b1;
            vecs[c].drdy = 1'b1;
            vecs[c].exp  = ev(st, 1'b1, (c == 13 || c == 17 || c == 21), 2'd1);
        end

        // Reset state
        #2;
        chk("reset_state", obs, 9'b100000001);
        @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 25; c++) begin
            cyc(vecs[c].pb, vecs[c].mode, vecs[c].srdy, vecs[c].drdy);
            chk($sformatf("nominal[%0d]", c), obs, vecs[c].exp);
        end

        // Glitch rejection: 2-cycle pulse never reaches the debounced level
        for (int k = 0; k < 14; k++) begin
            cyc((k < 2), 1'b0, 1'b1, 1'b1);
            chk($sformatf("glitch_busy[%0d]", k), 9'(busy), 9'd0);
        end

        // QPSK with a 5-cycle data_rdy drop in the first symbol
        nstb = 0;
        for (int k = 0; k < 30; k++) begin
            logic d;
            d = !(k >= 11 && k <= 15);
            cyc((k < 8), 1'b1, 1'b1, d);
            if (k >= 10 && k <= 26) begin
                chk($sformatf("pause_mod_en[%0d]", k), 9'(mod_en), 9'(d));
                chk($sformatf("pause_strobe[%0d]", k), 9'(sym_strobe),
                    9'(k == 18 || k == 22 || k == 26));
                if (sym_strobe) nstb++;
            end
            if (k == 12) chk("pause_bits", 9'(bits_per_sym), 9'd2);
            if (k == 27) chk("pause_done", obs, ev(c_S_DONE, 1'b0, 1'b0, 2'd2));
            if (k == 28) chk("pause_idle", obs, ev(c_S_IDLE, 1'b0, 1'b0, 2'd2));
        end
        chk("pause_strobe_count", 9'(nstb), 9'd3);

        // Timeout: generator never ready
        for (int k = 0; k < 35; k++) begin
            cyc((k < 8), 1'b0, 1'b0, 1'b1);
            if (k == 9)  chk("to_wait_entry", obs, ev(c_S_WAIT, 1'b0, 1'b0, 2'd1));
            if (k == 24) chk("to_wait_last", obs, ev(c_S_WAIT, 1'b0, 1'b0, 2'd1));
            if (k >= 25) chk($sformatf("to_error[%0d]", k), obs, ev(c_S_ERR, 1'b0, 1'b0, 2'd1));
        end

        // Press from ERROR clears err and re-arms (QPSK this time)
        for (int j = 0; j < 13; j++) begin
            cyc((j < 6), 1'b1, 1'b1, 1'b1);
            if (j == 6)  chk("err_hold_until_press", 9'(err), 9'd1);
            if (j == 7)  chk("err_clear_arm", obs, ev(c_S_ARM, 1'b0, 1'b0, 2'd2));
            if (j == 10) chk("rearm_run", obs, ev(c_S_RUN, 1'b1, 1'b0, 2'd2));
        end

        // Asynchronous reset between edges in RUN (strobe cycle)
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("pre_rst_run", obs, ev(c_S_RUN, 1'b1, 1'b1, 2'd2));
        #1 rst = 1'b1;
        #1 chk("async_rst_outputs", obs, 9'b100000001);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("post_rst_idle[%0d]", k), obs, ev(c_S_IDLE, 1'b0, 1'b0, 2'd1));
        end

        // Abort: second press during RUN
        for (int k = 0; k < 31; k++) begin
            cyc((k < 6) || (k >= 12 && k < 20), 1'b0, 1'b1, 1'b1);
            if (k == 10) chk("abort_run_start", obs, ev(c_S_RUN, 1'b1, 1'b0, 2'd1));
            if (k == 18) chk("abort_still_run", 9'(busy), 9'd1);
            if (k >= 19) chk($sformatf("abort_idle[%0d]", k), obs, ev(c_S_IDLE, 1'b0, 1'b0, 2'd1));
        end

        // sine_rdy falling in RUN is a fault
        for (int k = 0; k < 16; k++) begin
            cyc((k < 8), 1'b0, !(k >= 12), 1'b1);
            if (k == 11) chk("fault_run", obs, ev(c_S_RUN, 1'b1, 1'b0, 2'd1));
            if (k >= 13) chk($sformatf("fault_error[%0d]", k), obs, ev(c_S_ERR, 1'b0, 1'b0, 2'd1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
